// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle control sequencer: state encoding,
// PC source select values and the wait-counter width.
package mc_pkg;

   // Architectural state encoding; the numeric values are visible on the debug port.
   typedef enum logic [2:0] {
      S_IF    = 3'd0,
      S_IWAIT = 3'd1,
      S_ID    = 3'd2,
      S_EXE   = 3'd3,
      S_MEM   = 3'd4,
      S_MWAIT = 3'd5,
      S_WB    = 3'd6,
      S_HALT  = 3'd7
   } state_t;

   // PC source select: sequential pc+4 or branch/jump target.
   localparam logic PC_SEL_SEQ = 1'b0;
   localparam logic PC_SEL_TGT = 1'b1;

   // Memory latencies are 1..16, so the countdown fits in 4 bits.
   localparam int WAIT_W = $clog2(16);

endpackage

// File: rtl/mc_wait_cnt.sv
// Loadable down-counter shared by the instruction- and data-memory wait states.
// Holds at zero; load has priority over decrement.
import mc_pkg::*;

module mc_wait_cnt (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [WAIT_W-1:0] load_val,
   input  logic              dec,
   output logic              zero
);

   logic [WAIT_W-1:0] cnt_r;

   // Count register: cleared by reset, loaded on entry to a wait state, then counts down.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r <= {WAIT_W{1'b0}};
      end else if (load) begin
         cnt_r <= load_val;
      end else if (dec && (cnt_r != {WAIT_W{1'b0}})) begin
         cnt_r <= cnt_r - {{(WAIT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign zero = (cnt_r == {WAIT_W{1'b0}});

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Control sequencer for the multi-cycle core: walks IF/IWAIT/ID/EXE/MEM/MWAIT/WB,
// decodes every datapath write enable from the state, counts retired
// instructions and parks in HALT on an undecodable instruction.
import mc_pkg::*;

module mc_ctrl_fsm #(
   parameter int IMEM_LAT = 1,
   parameter int DMEM_LAT = 1,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic             dec_valid,
   input  logic             is_cbr,
   input  logic             is_b,
   input  logic             is_jmp_link,
   input  logic             is_load,
   input  logic             is_store,
   input  logic             gr_we,
   input  logic             br_taken,
   output logic             inst_sram_en,
   output logic             ir_we,
   output logic             data_sram_en,
   output logic             data_sram_we,
   output logic             mdr_we,
   output logic             rf_we,
   output logic             pc_we,
   output logic             pc_sel,
   output logic             retire,
   output logic [CNT_W-1:0] instret,
   output logic             halted,
   output logic [2:0]       state
);

   // Countdown start values: a latency of N means N-1 extra wait cycles after the strobe.
   localparam logic [WAIT_W-1:0] IMEM_INIT = WAIT_W'(IMEM_LAT - 1);
   localparam logic [WAIT_W-1:0] DMEM_INIT = WAIT_W'(DMEM_LAT - 1);

   state_t             state_r;
   state_t             next_state_s;
   logic               halted_r;
   logic               halt_set_s;
   logic [CNT_W-1:0]   instret_r;
   logic               wait_load_s;
   logic [WAIT_W-1:0]  wait_val_s;
   logic               wait_dec_s;
   logic               wait_zero_s;

   mc_wait_cnt u_wait_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (wait_load_s),
      .load_val (wait_val_s),
      .dec      (wait_dec_s),
      .zero     (wait_zero_s)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= S_IF;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Sticky halt flag, set when ID sees an undecodable instruction.
   always_ff @(posedge clk) begin
      if (reset) begin
         halted_r <= 1'b0;
      end else if (halt_set_s) begin
         halted_r <= 1'b1;
      end else begin
         halted_r <= halted_r;
      end
   end

   // Retired-instruction counter, wraps naturally at 2^CNT_W.
   always_ff @(posedge clk) begin
      if (reset) begin
         instret_r <= {CNT_W{1'b0}};
      end else if (retire) begin
         instret_r <= instret_r + CNT_W'(1);
      end else begin
         instret_r <= instret_r;
      end
   end

   // Next-state and strobe decode; reset suppresses every strobe so an
   // in-flight instruction cannot commit during the reset cycle.
   always_comb begin
      next_state_s = state_r;
      inst_sram_en = 1'b0;
      ir_we        = 1'b0;
      data_sram_en = 1'b0;
      data_sram_we = 1'b0;
      mdr_we       = 1'b0;
      rf_we        = 1'b0;
      pc_we        = 1'b0;
      pc_sel       = PC_SEL_SEQ;
      retire       = 1'b0;
      halt_set_s   = 1'b0;
      wait_load_s  = 1'b0;
      wait_val_s   = {WAIT_W{1'b0}};
      wait_dec_s   = 1'b0;

      if (reset) begin
         next_state_s = S_IF;
      end else begin
         case (state_r)
            S_IF: begin
               if (run) begin
                  inst_sram_en = 1'b1;
                  wait_load_s  = 1'b1;
                  wait_val_s   = IMEM_INIT;
                  next_state_s = S_IWAIT;
               end else begin
                  next_state_s = S_IF;
               end
            end
            S_IWAIT: begin
               if (wait_zero_s) begin
                  ir_we        = 1'b1;
                  next_state_s = S_ID;
               end else begin
                  wait_dec_s   = 1'b1;
                  next_state_s = S_IWAIT;
               end
            end
            S_ID: begin
               if (!dec_valid) begin
                  halt_set_s   = 1'b1;
                  next_state_s = S_HALT;
               end else if (is_cbr || is_b) begin
                  pc_we        = 1'b1;
                  pc_sel       = (is_b || br_taken) ? PC_SEL_TGT : PC_SEL_SEQ;
                  retire       = 1'b1;
                  next_state_s = S_IF;
               end else begin
                  next_state_s = S_EXE;
               end
            end
            S_EXE: begin
               if (is_load || is_store) begin
                  next_state_s = S_MEM;
               end else begin
                  next_state_s = S_WB;
               end
            end
            S_MEM: begin
               data_sram_en = 1'b1;
               data_sram_we = is_store;
               if (is_store) begin
                  pc_we        = 1'b1;
                  pc_sel       = PC_SEL_SEQ;
                  retire       = 1'b1;
                  next_state_s = S_IF;
               end else begin
                  wait_load_s  = 1'b1;
                  wait_val_s   = DMEM_INIT;
                  next_state_s = S_MWAIT;
               end
            end
            S_MWAIT: begin
               if (wait_zero_s) begin
                  mdr_we       = 1'b1;
                  next_state_s = S_WB;
               end else begin
                  wait_dec_s   = 1'b1;
                  next_state_s = S_MWAIT;
               end
            end
            S_WB: begin
               rf_we        = gr_we;
               pc_we        = 1'b1;
               pc_sel       = is_jmp_link ? PC_SEL_TGT : PC_SEL_SEQ;
               retire       = 1'b1;
               next_state_s = S_IF;
            end
            S_HALT: begin
               next_state_s = S_HALT;
            end
            default: begin
               next_state_s = S_IF;
            end
         endcase
      end
   end

   assign instret = instret_r;
   assign halted  = halted_r;
   assign state   = state_r;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm. Each instruction's expected strobe
// timeline is built from the latency rules (offsets from the fetch cycle),
// then compared cycle by cycle against the DUT.
module tb_mc_ctrl_fsm;

   localparam int IL = 3;
   localparam int DL = 2;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          run;
   logic          dec_valid, is_cbr, is_b, is_jmp_link, is_load, is_store, gr_we, br_taken;
   logic          inst_sram_en, ir_we, data_sram_en, data_sram_we, mdr_we, rf_we, pc_we, pc_sel, retire;
   logic [CW-1:0] instret;
   logic          halted;
   logic [2:0]    state;
   logic [8:0]    strobes;

   int checks   = 0;
   int failures = 0;
   int model_instret = 0;

   always #5 clk = ~clk;

   mc_ctrl_fsm #(.IMEM_LAT(IL), .DMEM_LAT(DL), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .run(run), .dec_valid(dec_valid),
      .is_cbr(is_cbr), .is_b(is_b), .is_jmp_link(is_jmp_link),
      .is_load(is_load), .is_store(is_store), .gr_we(gr_we), .br_taken(br_taken),
      .inst_sram_en(inst_sram_en), .ir_we(ir_we), .data_sram_en(data_sram_en),
      .data_sram_we(data_sram_we), .mdr_we(mdr_we), .rf_we(rf_we), .pc_we(pc_we),
      .pc_sel(pc_sel), .retire(retire), .instret(instret), .halted(halted), .state(state)
   );

   // bit 8..0: inst_sram_en ir_we data_sram_en data_sram_we mdr_we rf_we pc_we pc_sel retire
   assign strobes = {inst_sram_en, ir_we, data_sram_en, data_sram_we, mdr_we, rf_we, pc_we, pc_sel, retire};

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Called just after a negedge with the DUT in IF; runs one instruction.
   task automatic do_instr(input bit dv, input bit cbr, input bit b, input bit jl,
                           input bit ld, input bit st, input bit gw, input bit tk,
                           input bit mid_reset);
      logic [8:0] ev [0:63];
      int r;
      int n;
      int m;
      int ret_state;
      logic [8:0] mask;
      for (int i = 0; i < 64; i++) ev[i] = 9'd0;
      m = IL + 3;
      ret_state = 6;
      ev[0][8]  = 1'b1;
      ev[IL][7] = 1'b1;
      if (!dv) begin
         r = IL + 1;
      end else if (cbr || b) begin
         r = IL + 1;
         ret_state = 2;
         ev[r][2] = 1'b1; ev[r][1] = b | tk; ev[r][0] = 1'b1;
      end else if (ld || st) begin
         ev[m][6] = 1'b1;
         ev[m][5] = st;
         if (st) begin
            r = m;
            ret_state = 4;
            ev[r][2] = 1'b1; ev[r][1] = 1'b0; ev[r][0] = 1'b1;
         end else begin
            ev[m+DL][4] = 1'b1;
            r = m + DL + 1;
            ev[r][3] = gw; ev[r][2] = 1'b1; ev[r][1] = jl; ev[r][0] = 1'b1;
         end
      end else begin
         r = IL + 3;
         ev[r][3] = gw; ev[r][2] = 1'b1; ev[r][1] = jl; ev[r][0] = 1'b1;
      end
      n = r + 1;

      dec_valid = dv; is_cbr = cbr; is_b = b; is_jmp_link = jl;
      is_load = ld; is_store = st; gr_we = gw; br_taken = tk;

      for (int i = 0; i < n; i++) begin
         run = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         if (mid_reset && (i == IL + 4)) reset = 1'b1;
         #1;
         mask = ev[i][2] ? 9'h1FF : 9'h1FD;
         check_eq("strobes", 32'(strobes & mask), 32'(ev[i] & mask));
         if (i == 0)  check_eq("state_if", 32'(state), 32'd0);
         if (i == IL) check_eq("state_iwait", 32'(state), 32'd1);
         if (dv && (i == r)) check_eq("state_retire", 32'(state), 32'(ret_state));
         if (!dv && (i == r)) check_eq("state_id", 32'(state), 32'd2);
         if (dv && ld && !st && !cbr && !b && (i == m + DL))
            check_eq("state_mwait", 32'(state), 32'd5);
         if (mid_reset && (i == IL + 4)) begin
            check_eq("instret_before_rst", 32'(instret), 32'(model_instret));
            @(negedge clk);
            reset = 1'b0;
            run   = 1'b0;
            #1;
            model_instret = 0;
            check_eq("rst_state", 32'(state), 32'd0);
            check_eq("rst_instret", 32'(instret), 32'd0);
            check_eq("rst_strobes", 32'(strobes), 32'd0);
            for (int k = 0; k < 4; k++) begin
               @(negedge clk);
               #1;
               check_eq("post_rst_idle", 32'(strobes), 32'd0);
            end
            return;
         end
         if (ev[i][0]) model_instret = (model_instret + 1) % (1 << CW);
         @(negedge clk);
      end

      if (!dv) begin
         for (int k = 0; k < 21; k++) begin
            run = 1'b1;
            is_cbr = 1'($urandom); is_load = 1'($urandom); is_store = 1'($urandom);
            #1;
            check_eq("halt_state", 32'(state), 32'd7);
            check_eq("halt_flag", 32'(halted), 32'd1);
            check_eq("halt_strobes", 32'(strobes), 32'd0);
            @(negedge clk);
         end
         reset = 1'b1;
         @(negedge clk);
         reset = 1'b0;
         run   = 1'b0;
         #1;
         model_instret = 0;
         check_eq("halt_rst_state", 32'(state), 32'd0);
         check_eq("halt_rst_flag", 32'(halted), 32'd0);
         check_eq("halt_rst_instret", 32'(instret), 32'd0);
         return;
      end

      // Back in IF with run low: idle for a random number of cycles.
      run = 1'b0;
      #1;
      check_eq("idle_state", 32'(state), 32'd0);
      check_eq("instret", 32'(instret), 32'(model_instret));
      check_eq("idle_strobes", 32'(strobes), 32'd0);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
         @(negedge clk);
         #1;
         check_eq("idle_strobes", 32'(strobes), 32'd0);
      end
   endtask

   initial begin
      reset = 1'b1; run = 1'b0;
      dec_valid = 1'b1; is_cbr = 1'b0; is_b = 1'b0; is_jmp_link = 1'b0;
      is_load = 1'b0; is_store = 1'b0; gr_we = 1'b0; br_taken = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      check_eq("reset_state", 32'(state), 32'd0);
      check_eq("reset_strobes", 32'(strobes), 32'd0);
      check_eq("reset_instret", 32'(instret), 32'd0);
      check_eq("reset_halted", 32'(halted), 32'd0);
      @(negedge clk);

      //        dv cbr b jl ld st gw tk rst
      do_instr(1, 0, 0, 0, 0, 0, 1, 0, 0);   // add
      do_instr(1, 0, 0, 0, 1, 0, 1, 0, 0);   // ld.w
      do_instr(1, 1, 0, 0, 0, 0, 1, 1, 0);   // beq taken
      do_instr(1, 1, 0, 0, 0, 0, 1, 0, 0);   // beq not taken
      do_instr(1, 0, 1, 0, 0, 0, 0, 0, 0);   // b
      do_instr(1, 0, 0, 1, 0, 0, 1, 0, 0);   // jirl
      for (int j = 0; j < 20; j++) do_instr(1, 0, 0, 0, 0, 1, 0, 0, 0);   // stores, wraps instret

      for (int j = 0; j < 150; j++) begin
         do_instr(1, ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                  1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  1'($urandom), 1'($urandom), 0);
      end

      do_instr(1, 0, 0, 0, 1, 0, 1, 0, 1);   // load interrupted by reset in MWAIT
      do_instr(0, 0, 0, 0, 0, 0, 1, 0, 0);   // illegal -> HALT, then reset
      do_instr(1, 0, 0, 0, 0, 0, 1, 0, 0);   // core resumes after reset

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
